// File: rtl/priority_encoder_8to3.sv
// Registered 8-to-3 priority encoder with enable.
// Converts eight request lines into the binary index of the highest-numbered
// asserted line, plus a valid flag. The outputs come straight from flops, so
// there is no path from the request lines to the outputs that bypasses a clock edge.
module priority_encoder_8to3 (
  input  logic clk,
  input  logic rst,
  input  logic I_0,
  input  logic I_1,
  input  logic I_2,
  input  logic I_3,
  input  logic I_4,
  input  logic I_5,
  input  logic I_6,
  input  logic I_7,
  input  logic enable,
  output logic Y_0,
  output logic Y_1,
  output logic Y_2,
  output logic valid
);

  // Request vector, bit k = request line k (bit 7 has the highest priority).
  logic [7:0] req;
  assign req = {I_7, I_6, I_5, I_4, I_3, I_2, I_1, I_0};

  // higher_any[k] is set when some line above k is asserted.
  // win[k] is set when line k is the highest asserted line.
  // At most one bit of win can be set.
  logic [7:0] higher_any;
  logic [7:0] win;

  assign higher_any[7] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_higher
      assign higher_any[gi] = higher_any[gi+1] | req[gi+1];
    end
    for (gi = 0; gi < 8; gi++) begin : g_win
      assign win[gi] = req[gi] & ~higher_any[gi];
    end
  endgenerate

  // Index bit b is the OR of every winner position whose index has bit b set.
  // Because win is one-hot or zero, this gives the binary index of the winner.
  logic [2:0] idx;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_idx
      logic [7:0] sel_mask;
      for (genvar gj = 0; gj < 8; gj++) begin : g_mask
        assign sel_mask[gj] = ((gj >> gi) & 1) != 0;
      end
      assign idx[gi] = |(win & sel_mask);
    end
  endgenerate

  // Next-state values. When disabled or idle, the index drops back to zero.
  logic [2:0] y_next;
  logic       valid_next;

  // Gate the encoded result with enable and any-request.
  always_comb begin
    y_next     = 3'b000;
    valid_next = 1'b0;
    if (enable && (|req)) begin
      y_next     = idx;
      valid_next = 1'b1;
    end
  end

  // Output registers. Reset clears them immediately, without waiting for a clock edge.
  logic [2:0] y_reg;
  logic       valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg     <= 3'b000;
      valid_reg <= 1'b0;
    end else begin
      y_reg     <= y_next;
      valid_reg <= valid_next;
    end
  end

  assign Y_0   = y_reg[0];
  assign Y_1   = y_reg[1];
  assign Y_2   = y_reg[2];
  assign valid = valid_reg;

  // Unknown request or enable values have no defined encoding, so they are flagged here.
  a_inputs_known : assert property (
    @(posedge clk) disable iff (rst) !$isunknown({req, enable})
  );

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Directed testbench for priority_encoder_8to3.
module tb_priority_encoder_8to3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] i_vec = 8'h00;
  logic enable = 1'b0;
  logic Y_0, Y_1, Y_2, valid;

  int checks = 0;
  int failures = 0;

  priority_encoder_8to3 dut (
    .clk(clk), .rst(rst),
    .I_0(i_vec[0]), .I_1(i_vec[1]), .I_2(i_vec[2]), .I_3(i_vec[3]),
    .I_4(i_vec[4]), .I_5(i_vec[5]), .I_6(i_vec[6]), .I_7(i_vec[7]),
    .enable(enable),
    .Y_0(Y_0), .Y_1(Y_1), .Y_2(Y_2), .valid(valid)
  );

  always #5 clk = ~clk;

  // Compare {valid, Y_2, Y_1, Y_0} against the expected value.
  task automatic check_out(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got valid=%b y=%b, expected valid=%b y=%b",
               tag, got[3], got[2:0], exp[3], exp[2:0]);
    end else begin
      $display("ok   %s: valid=%b y=%b", tag, got[3], got[2:0]);
    end
  endtask

  function automatic logic [3:0] observed();
    return {valid, Y_2, Y_1, Y_0};
  endfunction

  // Independent reference: scan upward, so the last asserted index seen is the highest.
  function automatic logic [3:0] ref_model(input logic [7:0] v, input logic en);
    logic [3:0] r;
    r = 4'b0000;
    if (en) begin
      for (int k = 0; k < 8; k++) begin
        if (v[k]) r = {1'b1, 3'(k)};
      end
    end
    return r;
  endfunction

  // Drive inputs between edges, clock once, then sample 1 time unit after the edge.
  task automatic step(input string tag, input logic [7:0] v, input logic en,
                      input logic [3:0] exp);
    i_vec  = v;
    enable = en;
    @(posedge clk);
    #1;
    check_out(tag, observed(), exp);
  endtask

  initial begin
    // 1: reset held with all requests and enable active.
    rst = 1'b1;
    i_vec = 8'hFF;
    enable = 1'b1;
    #1;
    check_out("reset_async_initial", observed(), 4'b0000);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_out($sformatf("reset_held_%0d", c), observed(), 4'b0000);
    end
    @(negedge clk);
    rst = 1'b0;
    step("release_ff", 8'hFF, 1'b1, 4'b1111);

    // 2: one-hot walk.
    for (int k = 0; k < 8; k++) begin
      step($sformatf("onehot_%0d", k), 8'(1 << k), 1'b1, {1'b1, 3'(k)});
    end

    // 3: multiple requests.
    step("i0_i1", 8'h03, 1'b1, 4'b1001);
    step("i2_to_i7", 8'hFC, 1'b1, 4'b1111);
    step("i3_i6", 8'h48, 1'b1, 4'b1110);
    step("i0_i4", 8'h11, 1'b1, 4'b1100);

    // 4: idle versus index 0.
    step("all_zero", 8'h00, 1'b1, 4'b0000);
    step("only_i0", 8'h01, 1'b1, 4'b1000);

    // 5: enable toggling with I_5 held.
    step("en_on_i5", 8'h20, 1'b1, 4'b1101);
    step("en_off_i5", 8'h20, 1'b0, 4'b0000);
    step("en_back_i5", 8'h20, 1'b1, 4'b1101);
    step("en_off_ff", 8'hFF, 1'b0, 4'b0000);

    // 6: exhaustive sweep against the reference model.
    for (int p = 0; p < 256; p++) begin
      step($sformatf("sweep_%02h", p), 8'(p), 1'b1, ref_model(8'(p), 1'b1));
    end

    // Mid-cycle asynchronous reset: outputs clear before the next edge.
    step("pre_rst_i7", 8'h80, 1'b1, 4'b1111);
    #2;
    rst = 1'b1;
    #1;
    check_out("rst_mid_cycle", observed(), 4'b0000);
    @(posedge clk);
    #1;
    check_out("rst_mid_held_edge", observed(), 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    step("after_rst_idle", 8'h00, 1'b1, 4'b0000);
    step("after_rst_i2", 8'h04, 1'b1, 4'b1010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
